// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch entry type for the instruction fetch unit.
package fetch_pkg;

    localparam int DEF_INST_W     = 16;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam logic [DEF_INST_W-1:0] DEF_FILL_INST = 16'hE540;
    localparam int DEF_CNT_W      = $clog2(DEF_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
    } fetch_entry_t;

    // Count needs one extra bit so a full FIFO (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch entries; flush has priority over push and pop.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     din,
    input  logic                       pop,
    output entry_t                     head,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t             store [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;
    logic               push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    assign head    = store[rd_ptr];

    // NOTE: the storage is reset (unlike the instruction memory) so the head
    // presented to the CPU reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking updates let push and pop in one cycle both
            // see the pre-edge pointers and count.
            if (push_ok) begin
                store[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Writable instruction memory with fetch PC, prefetch FIFO and valid/ready output.
// Optional perf counters are built when INST_FETCH_PERF_EN is defined.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                INST_W     = DEF_INST_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [INST_W-1:0] FILL_INST  = DEF_FILL_INST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         prog_we,
    input  logic [ADDR_W-1:0]            prog_addr,
    input  logic [INST_W-1:0]            prog_data,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         inst_valid,
    output logic [INST_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_starve
`endif
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int OCC_W = CNT_W + 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [INST_W-1:0] mem [0:WORDS-1] = '{default: FILL_INST};

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rd_pc;
    logic [INST_W-1:0] rd_data;
    logic              inflight;
    logic              pop;
    logic              fifo_pop;
    logic              push_ret;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;
    entry_t            head;
    entry_t            ret_entry;

    assign inst_valid = (fifo_count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    // Redirect wins over both a same-cycle pop and a returning read.
    assign pop       = inst_valid && inst_ready;
    assign fifo_pop  = pop && !redirect_valid;
    assign push_ret  = inflight && !redirect_valid;
    assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = fetch_en && !redirect_valid && (occupancy < OCC_W'(FIFO_DEPTH));
    assign ret_entry = '{pc: rd_pc, inst: rd_data};

    // Same-address load and read in one cycle return the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        if (issue) begin
            rd_data <= mem[fetch_pc];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_pc    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                rd_pc    <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    prefetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_ret),
        .din   (ret_entry),
        .pop   (fifo_pop),
        .head  (head),
        .count (fifo_count)
    );

`ifdef INST_FETCH_PERF_EN
    // Saturating counters; redirect does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_starve  <= '0;
        end else begin
            if (fifo_pop && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (inst_ready && !inst_valid && (perf_starve != '1)) begin
                perf_starve <= perf_starve + 32'd1;
            end
        end
    end
`endif

endmodule
